// File: rtl/instr_seq_if.sv
// Load, control and instruction-launch signals of the instruction sequencer.
// The bench or host drives through master; the sequencer uses slave.
interface instr_seq_if;
    logic        ld_en;
    logic [3:0]  ld_addr;
    logic [13:0] ld_word;
    logic [3:0]  prog_len;
    logic        start;
    logic        Done;
    logic        Run;
    logic [1:0]  Rx;
    logic [1:0]  Ry;
    logic [1:0]  Fun;
    logic [7:0]  Data;
    logic        busy;
    logic [3:0]  pc;
    logic        err;

    modport master (
        output ld_en, ld_addr, ld_word, prog_len, start, Done,
        input  Run, Rx, Ry, Fun, Data, busy, pc, err
    );

    modport slave (
        input  ld_en, ld_addr, ld_word, prog_len, start, Done,
        output Run, Rx, Ry, Fun, Data, busy, pc, err
    );
endinterface

// File: rtl/instr_seq.sv
// Instruction sequencer: 16x14 program memory issued one word at a time,
// each launch waiting for Done from the datapath with a timeout.
module instr_seq #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    instr_seq_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ERR} state_e;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_e      state_q, state_d;
    logic [13:0] mem_q [16];
    logic [13:0] ins_q, ins_d;
    logic [3:0]  pc_q, pc_d;
    logic [3:0]  last_q, last_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;
    logic        run_q, run_d;
    logic        at_last, tmo;

    assign at_last = (pc_q == last_q);
    // Timeout fires on the TIMEOUT-th Done-less WAIT cycle; Done wins a tie.
    assign tmo     = (cnt_q == TMO_LAST);

    always_ff @(posedge clk) begin
        if (bus.ld_en && state_q == IDLE) begin
            mem_q[bus.ld_addr] <= bus.ld_word;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            ins_q   <= '0;
            pc_q    <= '0;
            last_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ins_q   <= ins_d;
            pc_q    <= pc_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            run_q   <= run_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT: begin
                if (bus.Done) begin
                    state_d = at_last ? IDLE : ISSUE;
                end else if (tmo) begin
                    state_d = ERR;
                end
            end
            ERR:     if (bus.start) state_d = ISSUE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ins_d  = ins_q;
        pc_d   = pc_q;
        last_d = last_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        err_d  = err_q;
        run_d  = 1'b0;
        unique case (state_q)
            IDLE, ERR: begin
                if (bus.start) begin
                    last_d = bus.prog_len;
                    pc_d   = '0;
                    busy_d = 1'b1;
                    err_d  = 1'b0;
                end
            end
            ISSUE: begin
                ins_d = mem_q[pc_q];
                run_d = 1'b1;
                cnt_d = '0;
            end
            WAIT: begin
                if (bus.Done) begin
                    if (at_last) begin
                        busy_d = 1'b0;
                        pc_d   = '0;
                    end else begin
                        pc_d = pc_q + 4'd1;
                    end
                end else if (tmo) begin
                    err_d  = 1'b1;
                    busy_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    assign bus.Run  = run_q;
    assign bus.Fun  = ins_q[13:12];
    assign bus.Rx   = ins_q[11:10];
    assign bus.Ry   = ins_q[9:8];
    assign bus.Data = ins_q[7:0];
    assign bus.busy = busy_q;
    assign bus.pc   = pc_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_instr_seq.sv
// Directed and randomized checks of instr_seq against a program-level
// model: expected launches are simply model[0..last] in order.
module tb_instr_seq;
    localparam int TO = 15;

    logic clk = 1'b0;
    logic reset;
    instr_seq_if bus();

    instr_seq #(.TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    logic [13:0] model [16];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] a, input logic [13:0] w);
        bus.ld_en   = 1'b1;
        bus.ld_addr = a;
        bus.ld_word = w;
        tick();
        bus.ld_en = 1'b0;
        model[a]  = w;
    endtask

    task automatic chk_fields(input string tag, input int idx);
        logic [13:0] w;
        w = model[4'(idx)];
        chk({tag, "_fun"}, 32'(bus.Fun), 32'(w[13:12]));
        chk({tag, "_rx"}, 32'(bus.Rx), 32'(w[11:10]));
        chk({tag, "_ry"}, 32'(bus.Ry), 32'(w[9:8]));
        chk({tag, "_data"}, 32'(bus.Data), 32'(w[7:0]));
    endtask

    // Run one program; fixed_d < 0 picks a random Done delay per word.
    task automatic exec(input logic [3:0] last, input int fixed_d,
                        input bit poke, input bit ld0);
        int d;
        bus.prog_len = last;
        bus.start    = 1'b1;
        if (ld0) begin
            bus.ld_en   = 1'b1;
            bus.ld_addr = 4'd0;
            bus.ld_word = model[0];
        end
        tick();
        bus.start    = 1'b0;
        bus.ld_en    = 1'b0;
        bus.prog_len = 4'($urandom);
        chk("issue_busy", 32'(bus.busy), 1);
        chk("issue_run", 32'(bus.Run), 0);
        for (int i = 0; i <= int'(last); i++) begin
            tick();
            chk("run", 32'(bus.Run), 1);
            chk("run_pc", 32'(bus.pc), 32'(i));
            chk_fields("run", i);
            d = (fixed_d >= 0) ? fixed_d : int'($urandom_range(0, TO - 1));
            for (int k = 0; k < d; k++) begin
                if (poke) begin
                    bus.start   = 1'b1;
                    bus.ld_en   = 1'b1;
                    bus.ld_addr = 4'($urandom);
                    bus.ld_word = 14'($urandom);
                end
                tick();
                bus.start = 1'b0;
                bus.ld_en = 1'b0;
                chk("wait_run", 32'(bus.Run), 0);
                chk("wait_pc", 32'(bus.pc), 32'(i));
                chk("hold_data", 32'(bus.Data), 32'(model[4'(i)][7:0]));
            end
            bus.Done = 1'b1;
            tick();
            bus.Done = 1'b0;
            chk("gap_run", 32'(bus.Run), 0);
            chk("no_err", 32'(bus.err), 0);
            if (i < int'(last)) chk("pc_inc", 32'(bus.pc), 32'(i + 1));
        end
        chk("end_busy", 32'(bus.busy), 0);
        chk("end_pc", 32'(bus.pc), 0);
        repeat (3) begin
            tick();
            chk("idle_run", 32'(bus.Run), 0);
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_run"}, 32'(bus.Run), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_err"}, 32'(bus.err), 0);
        chk({tag, "_pc"}, 32'(bus.pc), 0);
        chk({tag, "_fields"}, 32'({bus.Fun, bus.Rx, bus.Ry, bus.Data}), 0);
    endtask

    initial begin
        int runs;
        bus.ld_en    = 1'b0;
        bus.ld_addr  = '0;
        bus.ld_word  = '0;
        bus.prog_len = '0;
        bus.start    = 1'b0;
        bus.Done     = 1'b0;
        reset        = 1'b0;
        #1;
        chk_reset_outs("por");
        repeat (2) @(posedge clk);
        #2 reset = 1'b1;
        tick();

        for (int a = 0; a < 16; a++) load(4'(a), 14'($urandom));

        // Done while idle is ignored
        bus.Done = 1'b1;
        repeat (3) begin
            tick();
            chk("idle_done_run", 32'(bus.Run), 0);
        end
        bus.Done = 1'b0;
        chk("idle_done_busy", 32'(bus.busy), 0);

        load(4'd0, 14'h002A);
        load(4'd1, 14'h0105);
        exec(4'd1, 3, 1'b0, 1'b0);

        // Done on the last permitted WAIT cycle is success
        exec(4'd2, TO - 1, 1'b0, 1'b0);

        // Timeout: no Done ever
        bus.prog_len = 4'd3;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        chk("to_run", 32'(bus.Run), 1);
        for (int k = 1; k < TO; k++) begin
            tick();
            chk("to_pre_err", 32'(bus.err), 0);
            chk("to_pre_run", 32'(bus.Run), 0);
        end
        tick();
        chk("to_err", 32'(bus.err), 1);
        chk("to_busy", 32'(bus.busy), 0);
        chk("to_pc", 32'(bus.pc), 0);
        bus.Done    = 1'b1;
        bus.ld_en   = 1'b1;
        bus.ld_addr = 4'd0;
        bus.ld_word = ~model[0];
        runs = 0;
        repeat (4) begin
            tick();
            runs += int'(bus.Run);
        end
        bus.Done  = 1'b0;
        bus.ld_en = 1'b0;
        chk("err_no_run", 32'(runs), 0);
        chk("err_sticky", 32'(bus.err), 1);
        bus.prog_len = 4'd0;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("restart_err", 32'(bus.err), 0);
        chk("restart_busy", 32'(bus.busy), 1);
        tick();
        chk("restart_run", 32'(bus.Run), 1);
        chk_fields("restart", 0);
        bus.Done = 1'b1;
        tick();
        bus.Done = 1'b0;
        chk("restart_end", 32'(bus.busy), 0);

        // Reset in WAIT at pc=2
        bus.prog_len = 4'd5;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            bus.Done = 1'b1;
            tick();
            bus.Done = 1'b0;
        end
        tick();
        chk("rst_pre_run", 32'(bus.Run), 1);
        chk("rst_pre_pc", 32'(bus.pc), 2);
        tick();
        #2 reset = 1'b0;
        #1;
        chk_reset_outs("rst_mid");
        @(posedge clk);
        #2 reset = 1'b1;
        runs = 0;
        bus.Done = 1'b1;
        repeat (12) begin
            tick();
            runs += int'(bus.Run);
        end
        bus.Done = 1'b0;
        chk("rst_no_run", 32'(runs), 0);
        chk_reset_outs("rst_after");

        // Load with start, then ignored start/load while busy
        model[0] = 14'h3FFF;
        exec(4'd3, -1, 1'b1, 1'b1);
        exec(4'd3, -1, 1'b0, 1'b0);

        // Full program, no pc wrap
        exec(4'd15, -1, 1'b0, 1'b0);

        for (int r = 0; r < 5; r++) begin
            for (int a = 0; a < 16; a++) load(4'(a), 14'($urandom));
            exec(4'($urandom), -1, 1'($urandom), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
